// File: rtl/logic_unit_arbiter_if.sv
// Handshake bundle between two requesters, the shared logic unit and writeback.
// Master side: requesters plus the downstream consumer. Slave side: the arbiter.
interface logic_unit_arbiter_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [31:0] req0_A;
    logic [31:0] req0_B;
    logic [2:0]  req0_OpCode;

    logic        req1_valid;
    logic        req1_ready;
    logic [31:0] req1_A;
    logic [31:0] req1_B;
    logic [2:0]  req1_OpCode;

    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_Result;
    logic        resp_id;

    modport master (
        output req0_valid, req0_A, req0_B, req0_OpCode,
        output req1_valid, req1_A, req1_B, req1_OpCode,
        output resp_ready,
        input  req0_ready, req1_ready,
        input  resp_valid, resp_Result, resp_id
    );

    modport slave (
        input  req0_valid, req0_A, req0_B, req0_OpCode,
        input  req1_valid, req1_A, req1_B, req1_OpCode,
        input  resp_ready,
        output req0_ready, req1_ready,
        output resp_valid, resp_Result, resp_id
    );
endinterface

// File: rtl/logic_unit_arbiter.sv
// Two-port arbiter in front of one 32-bit logic/shift unit with a registered result.
// Latency: 1 cycle from accepted request to resp_valid; 1 op/cycle sustained.
// Backpressure: a full result register with !resp_ready deasserts both req ready.
module logic_unit_arbiter #(
    parameter int FAIR_RR = 1,
    parameter int CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    logic_unit_arbiter_if.slave  bus,
    output logic [CNT_W-1:0]     grant_cnt0,
    output logic [CNT_W-1:0]     grant_cnt1
);
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} stage_e;

    localparam logic             FAIR    = (FAIR_RR != 0);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    stage_e      state_q, state_d;
    logic        rr_q;
    logic        can_accept;
    logic        gnt0, gnt1, xfer, gnt_id;
    logic [31:0] op_a, op_b, result_d, result_q;
    logic [2:0]  op_code;
    logic        id_q;

    function automatic logic [31:0] lu_f(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] op);
        logic [31:0] r;
        case (op)
            3'b000:  r = a & b;
            3'b001:  r = a | b;
            3'b010:  r = a ^ b;
            3'b011:  r = ~(a | b);
            3'b100:  r = ~(a & b);
            3'b101:  r = ~(a ^ b);
            3'b110:  r = a << b[4:0];
            default: r = a >> b[4:0];
        endcase
        return r;
    endfunction

    // Grant depends only on valids, resp_ready and the rr pointer, never on operands.
    always_comb begin
        can_accept = (state_q == EMPTY) || bus.resp_ready;
        gnt0       = 1'b0;
        gnt1       = 1'b0;
        if (can_accept) begin
            if (bus.req0_valid && bus.req1_valid) begin
                if (FAIR && rr_q) gnt1 = 1'b1;
                else              gnt0 = 1'b1;
            end else begin
                gnt0 = bus.req0_valid;
                gnt1 = bus.req1_valid;
            end
        end
        xfer   = gnt0 | gnt1;
        gnt_id = gnt1;
    end

    always_comb begin
        op_a     = gnt_id ? bus.req1_A      : bus.req0_A;
        op_b     = gnt_id ? bus.req1_B      : bus.req0_B;
        op_code  = gnt_id ? bus.req1_OpCode : bus.req0_OpCode;
        result_d = lu_f(op_a, op_b, op_code);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: if (xfer) state_d = FULL;
            FULL:  if (bus.resp_ready && !xfer) state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            result_q   <= '0;
            id_q       <= 1'b0;
            rr_q       <= 1'b0;
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else begin
            state_q <= state_d;
            if (xfer) begin
                result_q <= result_d;
                id_q     <= gnt_id;
                // Pointer always moves to the port that did not win; fixed mode pins it at 0.
                rr_q     <= FAIR ? ~gnt_id : 1'b0;
            end
            if (gnt0 && grant_cnt0 != CNT_MAX) grant_cnt0 <= grant_cnt0 + 1'b1;
            if (gnt1 && grant_cnt1 != CNT_MAX) grant_cnt1 <= grant_cnt1 + 1'b1;
        end
    end

    assign bus.req0_ready  = gnt0;
    assign bus.req1_ready  = gnt1;
    assign bus.resp_valid  = (state_q == FULL);
    assign bus.resp_Result = result_q;
    assign bus.resp_id     = id_q;
endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Drives three arbiter builds (round-robin, fixed-priority, 2-bit counters) with shared
// stimulus and compares each against a cycle-level reference model every cycle.
module tb_logic_unit_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        v0 = 1'b0, v1 = 1'b0, rr_in = 1'b1;
    logic [31:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic [2:0]  op0 = '0, op1 = '0;

    logic_unit_arbiter_if bus_a ();
    logic_unit_arbiter_if bus_b ();
    logic_unit_arbiter_if bus_c ();

    logic [15:0] ca0, ca1, cb0, cb1;
    logic [1:0]  cc0, cc1;

    logic_unit_arbiter #(.FAIR_RR(1), .CNT_W(16)) dut_rr (
        .clk(clk), .rst_n(rst_n), .bus(bus_a), .grant_cnt0(ca0), .grant_cnt1(ca1));
    logic_unit_arbiter #(.FAIR_RR(0), .CNT_W(16)) dut_fp (
        .clk(clk), .rst_n(rst_n), .bus(bus_b), .grant_cnt0(cb0), .grant_cnt1(cb1));
    logic_unit_arbiter #(.FAIR_RR(1), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .bus(bus_c), .grant_cnt0(cc0), .grant_cnt1(cc1));

    assign bus_a.req0_valid = v0;  assign bus_b.req0_valid = v0;  assign bus_c.req0_valid = v0;
    assign bus_a.req0_A     = a0;  assign bus_b.req0_A     = a0;  assign bus_c.req0_A     = a0;
    assign bus_a.req0_B     = b0;  assign bus_b.req0_B     = b0;  assign bus_c.req0_B     = b0;
    assign bus_a.req0_OpCode = op0; assign bus_b.req0_OpCode = op0; assign bus_c.req0_OpCode = op0;
    assign bus_a.req1_valid = v1;  assign bus_b.req1_valid = v1;  assign bus_c.req1_valid = v1;
    assign bus_a.req1_A     = a1;  assign bus_b.req1_A     = a1;  assign bus_c.req1_A     = a1;
    assign bus_a.req1_B     = b1;  assign bus_b.req1_B     = b1;  assign bus_c.req1_B     = b1;
    assign bus_a.req1_OpCode = op1; assign bus_b.req1_OpCode = op1; assign bus_c.req1_OpCode = op1;
    assign bus_a.resp_ready = rr_in; assign bus_b.resp_ready = rr_in; assign bus_c.resp_ready = rr_in;

    logic        o_r0 [3], o_r1 [3], o_v [3], o_id [3];
    logic [31:0] o_res[3];
    logic [15:0] o_c0 [3], o_c1 [3];

    assign o_r0[0] = bus_a.req0_ready; assign o_r1[0] = bus_a.req1_ready;
    assign o_v[0]  = bus_a.resp_valid; assign o_id[0] = bus_a.resp_id;
    assign o_res[0] = bus_a.resp_Result; assign o_c0[0] = ca0; assign o_c1[0] = ca1;
    assign o_r0[1] = bus_b.req0_ready; assign o_r1[1] = bus_b.req1_ready;
    assign o_v[1]  = bus_b.resp_valid; assign o_id[1] = bus_b.resp_id;
    assign o_res[1] = bus_b.resp_Result; assign o_c0[1] = cb0; assign o_c1[1] = cb1;
    assign o_r0[2] = bus_c.req0_ready; assign o_r1[2] = bus_c.req1_ready;
    assign o_v[2]  = bus_c.resp_valid; assign o_id[2] = bus_c.resp_id;
    assign o_res[2] = bus_c.resp_Result; assign o_c0[2] = {14'd0, cc0}; assign o_c1[2] = {14'd0, cc1};

    // Reference model: per build, result stage contents, rr pointer, counters.
    bit          fair [3] = '{1'b1, 1'b0, 1'b1};
    int          cmax [3] = '{65535, 65535, 3};
    bit          mv   [3];
    logic [31:0] mres [3];
    bit          mid  [3];
    bit          mrr  [3];
    int          mc0  [3], mc1 [3];

    int n_chk = 0;
    int n_fail = 0;
    int w;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_op(input logic [31:0] a, input logic [31:0] b,
                                           input logic [2:0] op);
        int sh;
        sh = int'(b % 32);
        case (op)
            3'd0: return a & b;
            3'd1: return a | b;
            3'd2: return a ^ b;
            3'd3: return ~(a | b);
            3'd4: return ~(a & b);
            3'd5: return ~(a ^ b);
            3'd6: return a << sh;
            default: return a >> sh;
        endcase
    endfunction

    // Which port the build k grants this cycle, -1 for none.
    function automatic int winner(input int k);
        if (mv[k] && !rr_in) return -1;
        if (v0 && v1) return fair[k] ? (mrr[k] ? 1 : 0) : 0;
        if (v0) return 0;
        if (v1) return 1;
        return -1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            mv[k] = 0; mres[k] = '0; mid[k] = 0; mrr[k] = 0; mc0[k] = 0; mc1[k] = 0;
        end
    endtask

    task automatic model_clock();
        int wk [3];
        for (int k = 0; k < 3; k++) wk[k] = winner(k);
        for (int k = 0; k < 3; k++) begin
            if (wk[k] >= 0) begin
                mv[k]   = 1;
                mres[k] = (wk[k] == 1) ? ref_op(a1, b1, op1) : ref_op(a0, b0, op0);
                mid[k]  = (wk[k] == 1);
                if (wk[k] == 0) mc0[k] = (mc0[k] < cmax[k]) ? mc0[k] + 1 : cmax[k];
                else            mc1[k] = (mc1[k] < cmax[k]) ? mc1[k] + 1 : cmax[k];
                mrr[k]  = fair[k] ? (wk[k] == 0) : 1'b0;
            end else if (rr_in) begin
                mv[k] = 0;
            end
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rdy0[%0d]", k), o_r0[k], winner(k) == 0);
            chk($sformatf("rdy1[%0d]", k), o_r1[k], winner(k) == 1);
            chk($sformatf("valid[%0d]", k), o_v[k], mv[k]);
            if (mv[k]) begin
                chk($sformatf("result[%0d]", k), o_res[k], mres[k]);
                chk($sformatf("id[%0d]", k), o_id[k], mid[k]);
            end
            chk($sformatf("cnt0[%0d]", k), o_c0[k], mc0[k]);
            chk($sformatf("cnt1[%0d]", k), o_c1[k], mc1[k]);
        end
    endtask

    // Called at a negedge with inputs already driven; returns at the next negedge.
    task automatic step();
        #1 compare_all();
        @(posedge clk);
        model_clock();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; v0 = 1'b0; v1 = 1'b0; rr_in = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_valid[%0d]", k), o_v[k], 1'b0);
            chk($sformatf("rst_result[%0d]", k), o_res[k], 32'h0);
            chk($sformatf("rst_id[%0d]", k), o_id[k], 1'b0);
            chk($sformatf("rst_cnt[%0d]", k), {o_c0[k], o_c1[k]}, 32'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single AND on port 0
        v0 = 1'b1; a0 = 32'hF0F0_00FF; b0 = 32'h0FF0_0F0F; op0 = 3'd0;
        #1 chk("single_rdy0", o_r0[0], 1'b1);
        step();
        v0 = 1'b0;
        #1;
        chk("single_valid", o_v[0], 1'b1);
        chk("single_result", o_res[0], 32'h00F0_000F);
        chk("single_id", o_id[0], 1'b0);
        chk("single_cnt0", o_c0[0], 16'd1);
        step();

        // Contention: XOR on port 0 against shift-left on port 1
        do_reset();
        v0 = 1'b1; a0 = 32'hFFFF_0000; b0 = 32'h00FF_FF00; op0 = 3'd2;
        v1 = 1'b1; a1 = 32'h1;         b1 = 32'h1F;        op1 = 3'd6;
        for (int i = 0; i < 4; i++) begin
            step();
            #1;
            chk($sformatf("rr_id%0d", i), o_id[0], (i % 2) == 1);
            chk($sformatf("rr_res%0d", i), o_res[0], (i % 2) ? 32'h8000_0000 : 32'hFF00_FF00);
            chk($sformatf("fp_id%0d", i), o_id[1], 1'b0);
            chk($sformatf("fp_rdy1_%0d", i), o_r1[1], 1'b0);
        end
        chk("rr_cnts", {o_c0[0], o_c1[0]}, {16'd2, 16'd2});
        chk("fp_cnts", {o_c0[1], o_c1[1]}, {16'd4, 16'd0});
        v0 = 1'b0; v1 = 1'b0;
        step();

        // Back-pressure with port 1 waiting behind a full stage
        do_reset();
        rr_in = 1'b0;
        v0 = 1'b1; a0 = 32'h1234_5678; b0 = 32'h0; op0 = 3'd1;
        step();
        v0 = 1'b0;
        v1 = 1'b1; a1 = 32'hFFFF_0000; b1 = 32'h0; op1 = 3'd5;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("bp_rdy1_%0d", i), o_r1[0], 1'b0);
            chk($sformatf("bp_hold_%0d", i), o_res[0], 32'h1234_5678);
            step();
        end
        rr_in = 1'b1;
        #1 chk("bp_accept", o_r1[0], 1'b1);
        step();
        v1 = 1'b0;
        #1;
        chk("bp_valid", o_v[0], 1'b1);
        chk("bp_result", o_res[0], 32'h0000_FFFF);
        chk("bp_id", o_id[0], 1'b1);
        step();

        // Shift amount masking and NOR
        v0 = 1'b1; a0 = 32'h8000_0001; b0 = 32'hFFFF_FFE1; op0 = 3'd7;
        step();
        v0 = 1'b0;
        #1 chk("shr_mask", o_res[0], 32'h4000_0000);
        v0 = 1'b1; a0 = 32'h0; b0 = 32'h0; op0 = 3'd3;
        step();
        v0 = 1'b0;
        #1 chk("nor_zero", o_res[0], 32'hFFFF_FFFF);
        step();

        // Counter saturation
        do_reset();
        v0 = 1'b1; a0 = $urandom; b0 = $urandom; op0 = 3'd4;
        repeat (5) step();
        v0 = 1'b0;
        #1;
        chk("sat_cnt0_w2", o_c0[2], 16'd3);
        chk("sat_cnt0_w16", o_c0[0], 16'd5);
        step();

        // Asynchronous reset while the result stage is full
        rr_in = 1'b0;
        v0 = 1'b1; a0 = 32'hA5A5_A5A5; b0 = 32'h0F0F_0F0F; op0 = 3'd0;
        step();
        v0 = 1'b0;
        #1 chk("mr_full", o_v[0], 1'b1);
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) chk($sformatf("mr_async[%0d]", k), o_v[k], 1'b0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1; rr_in = 1'b1;
        step();
        #1 chk("mr_no_result", o_v[0], 1'b0);

        // Randomized traffic; requesters hold until build 0 accepts them
        for (int i = 0; i < 3000; i++) begin
            if (!v0 && $urandom_range(99) < 60) begin
                v0 = 1'b1; a0 = $urandom; b0 = $urandom; op0 = 3'($urandom_range(7));
            end
            if (!v1 && $urandom_range(99) < 60) begin
                v1 = 1'b1; a1 = $urandom; b1 = $urandom; op1 = 3'($urandom_range(7));
            end
            rr_in = ($urandom_range(99) < 70);
            w = winner(0);
            step();
            if (w == 0) begin
                v0 = 1'($urandom_range(1)); a0 = $urandom; b0 = $urandom; op0 = 3'($urandom_range(7));
            end
            if (w == 1) begin
                v1 = 1'($urandom_range(1)); a1 = $urandom; b1 = $urandom; op1 = 3'($urandom_range(7));
            end
        end
        v0 = 1'b0; v1 = 1'b0; rr_in = 1'b1;
        step();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/logic_unit_arbiter.md
Name: logic_unit_arbiter

Overview:
- Shares one 32-bit logical/shift unit between two requesters, e.g. the integer issue port and the address-generation/CSR path.
- Uses a valid/ready handshake on each request port, a round-robin or fixed-priority grant, and a one-entry registered result stage with back-pressure.
- Sits between issue logic and writeback.
- The unit's function is computed combinationally (opcode encoding below); its result is registered inside this block.

Parameters:
- FAIR_RR, 1: 1 = round-robin grant; 0 = fixed priority, port 0 wins.
- CNT_W, 16: width of the per-port saturating grant counters.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req0_valid  input  1  port 0 request valid.
- req0_ready  output  1  port 0 accepted this cycle.
- req0_A  input  32  port 0 operand A.
- req0_B  input  32  port 0 operand B.
- req0_OpCode  input  3  port 0 operation.
- req1_valid, req1_ready, req1_A, req1_B, req1_OpCode: same widths and meanings, port 1.
- resp_valid  output  1  result register holds valid data.
- resp_ready  input  1  downstream consumes result.
- resp_Result  output  32  registered result.
- resp_id  output  1  requester that produced the result (0/1).
- grant_cnt0  output  CNT_W  saturating count of port 0 grants.
- grant_cnt1  output  CNT_W  saturating count of port 1 grants.

Behaviour:
- Opcode encoding on A, B:
  - 000 AND, 001 OR, 010 XOR, 011 NOR, 100 NAND, 101 XNOR.
  - 110 A<<B[4:0], 111 A>>B[4:0] (logical; B[31:5] ignored).
- Reset (async assert, sync-safe deassert): resp_valid=0, resp_Result=0, resp_id=0, rr pointer=0 (port 0 preferred), grant_cnt0=grant_cnt1=0.
- Reset mid-operation drops any in-flight result; no response is produced for it.
- Output stage is either EMPTY (resp_valid=0) or FULL (resp_valid=1).
- can_accept = !resp_valid | resp_ready, i.e. empty, or draining this cycle.
- Grant (combinational, same cycle):
  - Only one valid: that port is granted if can_accept.
  - Both valid, FAIR_RR=1: the port named by the rr pointer is granted.
  - Both valid, FAIR_RR=0: port 0 is granted.
  - reqX_ready = grant to X. At most one ready high per cycle; never high when !can_accept.
- reqX_ready may depend combinationally on both valids and on resp_ready. Requesters must not derive valid from ready.
- Transfer: reqX_valid & reqX_ready at edge N.
  - At N+1: resp_valid=1, resp_Result = f(A, B, OpCode) sampled at N, resp_id = X.
  - Latency is exactly 1 cycle.
- Drain and refill in the same cycle (FULL & resp_ready & new grant): the register loads the new result; resp_valid stays 1. Throughput is 1 op/cycle.
- Drain with no grant: resp_valid -> 0 next cycle.
- FULL & !resp_ready: resp_Result and resp_id are held stable; both reqX_ready=0.
- Requester protocol: once valid is raised it is held with stable A/B/OpCode until accepted. The block does not check this.
- rr pointer: updates only on a transfer, to the non-granted port (1-grant_id).
  - A lone requester that is granted also moves the pointer away from itself.
  - In fixed mode the pointer is unused and holds 0.
- grant_cntX increments on each port X transfer and saturates at 2^CNT_W-1 (no wrap).
- No combinational path from reqX_A/B/OpCode to any output.

Test Plan:
- Reset then single op: req0 A=0xF0F0_00FF, B=0x0FF0_0F0F, OpCode=000 -> req0_ready=1 in the same cycle; next cycle resp_valid=1, resp_Result=0x00F0_000F, resp_id=0, grant_cnt0=1.
- Contention, FAIR_RR=1: both valid for 4 cycles with resp_ready=1, port 0 XOR (A=0xFFFF_0000, B=0x00FF_FF00) and port 1 shift-left (A=0x1, B=0x1F) -> resp_id sequence 0,1,0,1; results alternate 0xFF00_FF00 / 0x8000_0000; cnt0=cnt1=2.
- Contention, FAIR_RR=0: same stimulus -> all four grants go to port 0; req1_ready stays 0.
- Back-pressure: fill result register, hold resp_ready=0 for 3 cycles with req1 valid -> req1_ready=0 and resp_Result stable throughout; when resp_ready=1, req1 is accepted the same cycle and its result appears the next cycle with no bubble.
- Shift masking and NOR: A=0x8000_0001, B=0xFFFF_FFE1, OpCode=111 -> Result=0x4000_0000. A=0, B=0, OpCode=011 -> Result=0xFFFF_FFFF.
- Reset mid-operation and saturation:
  - Assert rst_n low while resp_valid=1 -> resp_valid=0 immediately (async) and no result appears after release.
  - With CNT_W=2 and 5 port 0 grants -> grant_cnt0=3.
